pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the program-counter and address width in bits.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-address stack entries (power of 2, minimum 2).
REQ-003 The block SHALL have parameter RESET_ADDR, default 0, meaning the PC value after reset.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port reg_input, input, ADDR_W bits: absolute target for load and call.
REQ-007 The block SHALL have port reg_load, input, 1 bit: absolute jump request.
REQ-008 The block SHALL have port reg_inc, input, 1 bit: sequential increment request.
REQ-009 The block SHALL have port rel_branch, input, 1 bit: relative branch request.
REQ-010 The block SHALL have port rel_offset, input, ADDR_W bits: two's-complement branch offset.
REQ-011 The block SHALL have port call, input, 1 bit: push the return address and jump to reg_input.
REQ-012 The block SHALL have port ret, input, 1 bit: pop the return address into the PC.
REQ-013 The block SHALL have port stall, input, 1 bit: freeze the PC and the stack.
REQ-014 The block SHALL have port PC_address, output, ADDR_W bits: registered current PC.
REQ-015 The block SHALL have port ROM_address, output, ADDR_W bits: combinationally equal to PC_address.
REQ-016 The block SHALL have port stack_full, output, 1 bit: high when occupancy equals STACK_DEPTH.
REQ-017 The block SHALL have port stack_empty, output, 1 bit: high when occupancy is 0.
REQ-018 The block SHALL have port stack_err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-019 Per-cycle priority SHALL be, highest first: Rst, stall, ret, call, reg_load, rel_branch, reg_inc, hold; only the highest-priority asserted request takes effect.
REQ-020 reg_load SHALL set PC to reg_input on the next edge (latency 1 cycle).
REQ-021 reg_inc SHALL set PC to (PC+1) mod 2^ADDR_W; all-ones wraps to 0.
REQ-022 rel_branch SHALL set PC to (PC + sign-extended rel_offset) mod 2^ADDR_W, with no overflow detection.
REQ-023 call with stack not full SHALL write (PC+1) mod 2^ADDR_W to stack[occupancy], increment occupancy, and set PC to reg_input in the same edge.
REQ-024 call with stack full SHALL leave PC, stack and occupancy unchanged and set stack_err.
REQ-025 ret with stack not empty SHALL decrement occupancy and set PC to stack[occupancy-1] in the same edge.
REQ-026 ret with stack empty SHALL leave PC and occupancy unchanged and set stack_err.
REQ-027 stall SHALL hold PC, stack contents, occupancy and stack_err regardless of other requests.
REQ-028 The occupancy counter SHALL be clog2(STACK_DEPTH)+1 bits wide, range 0..STACK_DEPTH, and never wrap.
REQ-029 stack_full and stack_empty SHALL be decoded from registered occupancy, with no combinational path from request inputs.
REQ-030 stack_err SHALL remain high until Rst once set.
REQ-031 Stack entries above occupancy SHALL NOT be observable and their contents SHALL be don't-care.

Reset
REQ-032 Rst high at a rising edge SHALL set PC_address=RESET_ADDR, occupancy=0, stack_err=0, overriding stall and all requests.
REQ-033 After reset, stack_empty=1, stack_full=0, and ROM_address=RESET_ADDR.
REQ-034 Rst asserted mid-sequence, including on the same edge as call or ret, SHALL discard the pending push or pop.
REQ-035 Stack storage SHALL NOT require reset.

Verification
REQ-036 Bench SHALL check: Rst, then reg_inc held for 256 cycles (ADDR_W=8) -> PC 0,1,...,255,0; ROM_address tracks PC each cycle.
REQ-037 Bench SHALL check: PC=0x10, rel_offset=0xFC with rel_branch -> PC=0x0C; PC=0xFE, rel_offset=0x05 -> PC=0x03.
REQ-038 Bench SHALL check: PC=0x20, call with reg_input=0x80 -> PC=0x80, stack_empty=0; then ret -> PC=0x21, stack_empty=1.
REQ-039 Bench SHALL check: four nested calls (STACK_DEPTH=4) -> stack_full=1; a fifth call -> PC unchanged, stack_err=1; four rets return the addresses in LIFO order; a fifth ret -> PC unchanged, stack_err stays 1.
REQ-040 Bench SHALL check: stall held with call, reg_load and reg_inc all high -> PC and occupancy unchanged; call and reg_load together -> call wins.
REQ-041 Bench SHALL check: Rst on the same edge as call with occupancy 2 -> PC=RESET_ADDR, stack_empty=1, stack_err=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with absolute load, increment,
// relative branch and a small return-address stack for call/ret.
// One request is honoured per cycle in fixed priority order; stall freezes
// everything except reset.
module pc_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] reg_input,
    input  logic              reg_load,
    input  logic              reg_inc,
    input  logic              rel_branch,
    input  logic [ADDR_W-1:0] rel_offset,
    input  logic              call,
    input  logic              ret,
    input  logic              stall,
    output logic [ADDR_W-1:0] PC_address,
    output logic [ADDR_W-1:0] ROM_address,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    // Index width into the stack array, and occupancy width which needs one
    // extra bit so that "completely full" is representable without wrapping.
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc;
    logic [OCC_W-1:0]  occupancy;
    logic              err;

    // Return-address storage; entries at or above occupancy are dead and
    // are never read, so the array carries no reset.
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_plus_one;
    logic [ADDR_W-1:0] pc_branch;
    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  pop_idx;
    logic              full;
    logic              empty;
    logic              active;
    logic              do_ret;
    logic              do_call;
    logic              do_push;
    logic              do_pop;
    logic              ret_fault;
    logic              call_fault;

    // Flags come only from the registered occupancy, never from requests.
    assign full  = (occupancy == OCC_W'(STACK_DEPTH));
    assign empty = (occupancy == '0);

    // Decode which single request wins this cycle and the candidate next
    // PCs. Adding an ADDR_W-bit offset modulo 2^ADDR_W is identical to
    // adding its sign-extended value, so no explicit extension is needed.
    always_comb begin
        pc_plus_one = pc + ADDR_W'(1);
        pc_branch   = pc + rel_offset;
        push_idx    = occupancy[PTR_W-1:0];
        pop_idx     = PTR_W'(occupancy - OCC_W'(1));
        active      = !Rst && !stall;
        do_ret      = active && ret;
        do_call     = active && !ret && call;
        do_pop      = do_ret && !empty;
        do_push     = do_call && !full;
        ret_fault   = do_ret && empty;
        call_fault  = do_call && full;
    end

    // Main PC / occupancy / error state update in priority order:
    // reset, stall, ret, call, load, branch, increment, hold.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc        <= RESET_ADDR;
            occupancy <= '0;
            err       <= 1'b0;
        end else if (stall) begin
            pc        <= pc;
            occupancy <= occupancy;
            err       <= err;
        end else if (ret) begin
            if (do_pop) begin
                pc        <= stack_mem[pop_idx];
                occupancy <= occupancy - OCC_W'(1);
            end
            if (ret_fault) begin
                err <= 1'b1;
            end
        end else if (call) begin
            if (do_push) begin
                pc        <= reg_input;
                occupancy <= occupancy + OCC_W'(1);
            end
            if (call_fault) begin
                err <= 1'b1;
            end
        end else if (reg_load) begin
            pc <= reg_input;
        end else if (rel_branch) begin
            pc <= pc_branch;
        end else if (reg_inc) begin
            pc <= pc_plus_one;
        end
    end

    // Push the return address into the slot just above the current top.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= pc_plus_one;
        end
    end

    assign PC_address  = pc;
    assign ROM_address = pc;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic for
// pc_sequencer, checked against a queue-based reference model.
module tb_pc_sequencer;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int MODV   = 256;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic [ADDR_W-1:0] reg_input = '0;
    logic              reg_load = 1'b0;
    logic              reg_inc = 1'b0;
    logic              rel_branch = 1'b0;
    logic [ADDR_W-1:0] rel_offset = '0;
    logic              call = 1'b0;
    logic              ret = 1'b0;
    logic              stall = 1'b0;
    logic [ADDR_W-1:0] PC_address;
    logic [ADDR_W-1:0] ROM_address;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_pc  = 0;
    int m_stack[$];
    bit m_err = 1'b0;

    pc_sequencer #(
        .ADDR_W(ADDR_W),
        .STACK_DEPTH(DEPTH),
        .RESET_ADDR(8'h00)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .reg_input(reg_input),
        .reg_load(reg_load),
        .reg_inc(reg_inc),
        .rel_branch(rel_branch),
        .rel_offset(rel_offset),
        .call(call),
        .ret(ret),
        .stall(stall),
        .PC_address(PC_address),
        .ROM_address(ROM_address),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .stack_err(stack_err)
    );

    always #5 Clk = ~Clk;

    // Behavioural model of one rising edge, straight from the request rules.
    task automatic model_edge();
        int off;
        if (Rst) begin
            m_pc = 0;
            m_stack.delete();
            m_err = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else m_pc = m_stack.pop_back();
        end else if (call) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else begin
                m_stack.push_back((m_pc + 1) % MODV);
                m_pc = int'(reg_input);
            end
        end else if (reg_load) begin
            m_pc = int'(reg_input);
        end else if (rel_branch) begin
            off  = (rel_offset >= 8'h80) ? int'(rel_offset) - MODV : int'(rel_offset);
            m_pc = (((m_pc + off) % MODV) + MODV) % MODV;
        end else if (reg_inc) begin
            m_pc = (m_pc + 1) % MODV;
        end
    endtask

    // Drive one cycle of requests, advance the model, sample 1 ns after the edge.
    task automatic applyStimulus(input logic r, input logic st, input logic rt,
                                 input logic cl, input logic ld, input logic rb,
                                 input logic inc, input logic [7:0] in_v,
                                 input logic [7:0] off_v);
        Rst = r; stall = st; ret = rt; call = cl;
        reg_load = ld; rel_branch = rb; reg_inc = inc;
        reg_input = in_v; rel_offset = off_v;
        @(posedge Clk);
        model_edge();
        #1;
        Rst = 0; stall = 0; ret = 0; call = 0;
        reg_load = 0; rel_branch = 0; reg_inc = 0;
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, 1, 1, 1, 1, 1, 8'h5A, 8'h33);
        vectors++; if (PC_address !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_pc: got %0h expected 00", PC_address); end
        vectors++; if (ROM_address !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rom: got %0h expected 00", ROM_address); end
        vectors++; if (stack_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b expected 1", stack_empty); end
        vectors++; if (stack_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", stack_full); end
        vectors++; if (stack_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", stack_err); end
    endtask

    task automatic test_increment();
        logic [7:0] exp_pc;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) begin
            exp_pc = 8'(i + 1);
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
            vectors++; if (PC_address !== exp_pc) begin miscompares++; $display("[TB] FAIL inc_pc[%0d]: got %0h expected %0h", i, PC_address, exp_pc); end
            vectors++; if (ROM_address !== exp_pc) begin miscompares++; $display("[TB] FAIL inc_rom[%0d]: got %0h expected %0h", i, ROM_address, exp_pc); end
        end
    endtask

    task automatic test_rel_branch();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'h10, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFC);
        vectors++; if (PC_address !== 8'h0C) begin miscompares++; $display("[TB] FAIL branch_back: got %0h expected 0c", PC_address); end
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'hFE, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h05);
        vectors++; if (PC_address !== 8'h03) begin miscompares++; $display("[TB] FAIL branch_wrap: got %0h expected 03", PC_address); end
    endtask

    task automatic test_call_ret();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'h20, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 8'h80, 8'h00);
        vectors++; if (PC_address !== 8'h80) begin miscompares++; $display("[TB] FAIL call_pc: got %0h expected 80", PC_address); end
        vectors++; if (stack_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL call_empty: got %b expected 0", stack_empty); end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        vectors++; if (PC_address !== 8'h21) begin miscompares++; $display("[TB] FAIL ret_pc: got %0h expected 21", PC_address); end
        vectors++; if (stack_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL ret_empty: got %b expected 1", stack_empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ret[$];
        logic [7:0] cur;
        logic [7:0] tgt;
        logic [7:0] want;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'h40, 8'h00);
        cur = 8'h40;
        for (int i = 0; i < DEPTH; i++) begin
            tgt = 8'($urandom_range(0, 255));
            exp_ret.push_back(cur + 8'd1);
            applyStimulus(0, 0, 0, 1, 0, 0, 0, tgt, 8'h00);
            cur = tgt;
            vectors++; if (PC_address !== tgt) begin miscompares++; $display("[TB] FAIL nest_call[%0d]: got %0h expected %0h", i, PC_address, tgt); end
        end
        vectors++; if (stack_full !== 1'b1) begin miscompares++; $display("[TB] FAIL nest_full: got %b expected 1", stack_full); end
        vectors++; if (stack_err !== 1'b0) begin miscompares++; $display("[TB] FAIL nest_err_clean: got %b expected 0", stack_err); end
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 8'hEE, 8'h00);
        vectors++; if (PC_address !== cur) begin miscompares++; $display("[TB] FAIL over_pc: got %0h expected %0h", PC_address, cur); end
        vectors++; if (stack_err !== 1'b1) begin miscompares++; $display("[TB] FAIL over_err: got %b expected 1", stack_err); end
        for (int i = 0; i < DEPTH; i++) begin
            want = exp_ret.pop_back();
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
            cur = want;
            vectors++; if (PC_address !== want) begin miscompares++; $display("[TB] FAIL lifo_ret[%0d]: got %0h expected %0h", i, PC_address, want); end
        end
        vectors++; if (stack_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL lifo_empty: got %b expected 1", stack_empty); end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        vectors++; if (PC_address !== cur) begin miscompares++; $display("[TB] FAIL under_pc: got %0h expected %0h", PC_address, cur); end
        vectors++; if (stack_err !== 1'b1) begin miscompares++; $display("[TB] FAIL under_err: got %b expected 1", stack_err); end
    endtask

    task automatic test_stall();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'h30, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 8'h50, 8'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 1, 1, 0, 1, 8'h99, 8'h00);
            vectors++; if (PC_address !== 8'h50) begin miscompares++; $display("[TB] FAIL stall_pc[%0d]: got %0h expected 50", i, PC_address); end
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        vectors++; if (PC_address !== 8'h31) begin miscompares++; $display("[TB] FAIL stall_ret_pc: got %0h expected 31", PC_address); end
        vectors++; if (stack_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_occ: got %b expected 1", stack_empty); end
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 8'hA7, 8'h00);
        vectors++; if (PC_address !== 8'hA7) begin miscompares++; $display("[TB] FAIL call_load_pc: got %0h expected a7", PC_address); end
        vectors++; if (stack_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL call_wins: got empty=%b expected 0", stack_empty); end
    endtask

    task automatic test_reset_with_call();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 8'h11, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 8'h22, 8'h00);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 8'h33, 8'h00);
        vectors++; if (PC_address !== 8'h00) begin miscompares++; $display("[TB] FAIL rstcall_pc: got %0h expected 00", PC_address); end
        vectors++; if (stack_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rstcall_empty: got %b expected 1", stack_empty); end
        vectors++; if (stack_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rstcall_err: got %b expected 0", stack_err); end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        vectors++; if (stack_err !== 1'b1) begin miscompares++; $display("[TB] FAIL rstcall_discard: got err=%b expected 1", stack_err); end
    endtask

    task automatic test_random();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 0),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            vectors++; if (int'(PC_address) !== m_pc) begin miscompares++; $display("[TB] FAIL rand_pc[%0d]: got %0h expected %0h", i, PC_address, m_pc); end
            vectors++; if (ROM_address !== 8'(m_pc)) begin miscompares++; $display("[TB] FAIL rand_rom[%0d]: got %0h expected %0h", i, ROM_address, m_pc); end
            vectors++; if (stack_full !== (m_stack.size() == DEPTH)) begin miscompares++; $display("[TB] FAIL rand_full[%0d]: got %b expected occ %0d", i, stack_full, m_stack.size()); end
            vectors++; if (stack_empty !== (m_stack.size() == 0)) begin miscompares++; $display("[TB] FAIL rand_empty[%0d]: got %b expected occ %0d", i, stack_empty, m_stack.size()); end
            vectors++; if (stack_err !== m_err) begin miscompares++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b", i, stack_err, m_err); end
        end
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        @(negedge Clk);
        test_reset();
        test_increment();
        test_rel_branch();
        test_call_ret();
        test_overflow();
        test_stall();
        test_reset_with_call();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no completion expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
